// File: rtl/barrel_shifter_pipe.sv
// Pipelined LSL/LSR/ASR/ROR barrel shifter; latency SHAMT_W cycles (PIPE=1) or 1 (PIPE=0); whole pipe stalls
// when out_valid & !out_ready. Define BSHIFT_FLAGS_EN to add the out_zero/out_carry flag outputs.
module barrel_shifter_pipe #(
  parameter  int WIDTH   = 8,
  parameter  int PIPE    = 1,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data
`ifdef BSHIFT_FLAGS_EN
  ,
  output logic               out_zero,
  output logic               out_carry
`endif
);

  localparam int LAST = SHAMT_W - 1;

  typedef enum logic [1:0] {
    M_LSL = 2'b00,
    M_LSR = 2'b01,
    M_ASR = 2'b10,
    M_ROR = 2'b11
  } mode_e;

  // sign is the original operand MSB, captured once so ASR fill never depends on partially shifted data
  typedef struct packed {
    logic               vld;
    mode_e              mode;
    logic [SHAMT_W-1:0] shamt;
    logic               sign;
`ifdef BSHIFT_FLAGS_EN
    logic               cy;
`endif
    logic [WIDTH-1:0]   dat;
  } stage_t;

  stage_t stage_in [SHAMT_W];
  stage_t stage_d  [SHAMT_W];
  stage_t head;
  logic   advance;

  logic             tail_vld_q;
  logic [WIDTH-1:0] tail_dat_q;

  assign advance  = !tail_vld_q || out_ready;
  assign in_ready = advance;

  always_comb begin
    head       = '0;
    head.vld   = in_valid;
    head.mode  = mode_e'(in_mode);
    head.shamt = in_shamt;
    head.sign  = in_data[WIDTH-1];
    head.dat   = in_data;
  end

  assign stage_in[0] = head;

  for (genvar i = 0; i < SHAMT_W; i++) begin : g_lvl
    localparam int K = 2 ** i;
    stage_t lvl_d;

    always_comb begin
      lvl_d = stage_in[i];
      if (stage_in[i].shamt[i]) begin
        case (stage_in[i].mode)
          M_LSL:   lvl_d.dat = stage_in[i].dat << K;
          M_LSR:   lvl_d.dat = stage_in[i].dat >> K;
          M_ASR:   lvl_d.dat = (stage_in[i].dat >> K) | ({WIDTH{stage_in[i].sign}} << (WIDTH - K));
          default: lvl_d.dat = (stage_in[i].dat >> K) | (stage_in[i].dat << (WIDTH - K));
        endcase
`ifdef BSHIFT_FLAGS_EN
        // The last active level wins, so the final carry is the last bit shifted out overall
        case (stage_in[i].mode)
          M_LSL:   lvl_d.cy = stage_in[i].dat[WIDTH-K];
          M_ROR:   lvl_d.cy = lvl_d.dat[WIDTH-1];
          default: lvl_d.cy = stage_in[i].dat[K-1];
        endcase
`endif
      end
    end

    assign stage_d[i] = lvl_d;

    if (i < LAST) begin : g_link
      if (PIPE != 0) begin : g_reg
        stage_t stage_q;
        always_ff @(posedge clk) begin
          if (rst) begin
            stage_q <= '0;
          end else if (advance) begin
            stage_q <= lvl_d;
          end
        end
        assign stage_in[i+1] = stage_q;
      end else begin : g_comb
        assign stage_in[i+1] = lvl_d;
      end
    end
  end

`ifdef BSHIFT_FLAGS_EN
  logic tail_zero_q;
  logic tail_cy_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      tail_vld_q  <= 1'b0;
      tail_dat_q  <= '0;
`ifdef BSHIFT_FLAGS_EN
      tail_zero_q <= 1'b0;
      tail_cy_q   <= 1'b0;
`endif
    end else if (advance) begin
      tail_vld_q  <= stage_d[LAST].vld;
      tail_dat_q  <= stage_d[LAST].dat;
`ifdef BSHIFT_FLAGS_EN
      tail_zero_q <= (stage_d[LAST].dat == '0);
      tail_cy_q   <= stage_d[LAST].cy;
`endif
    end
  end

  assign out_valid = tail_vld_q;
  assign out_data  = tail_dat_q;
`ifdef BSHIFT_FLAGS_EN
  assign out_zero  = tail_zero_q;
  assign out_carry = tail_cy_q;
`endif

endmodule
